// File: rtl/pipelined_carry_select_adder_if.sv
// pipelined_carry_select_adder_if: operand/result handshake bundle for the carry-select adder
interface pipelined_carry_select_adder_if #(parameter int W = 32);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: parametrised carry-select add/subtract spread over STAGES registers
module pipelined_carry_select_adder #(
    parameter int W      = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst,
    pipelined_carry_select_adder_if.slave p
);
    localparam int G  = W / (BLK * STAGES);
    localparam int SW = G * BLK;
    logic adv;
    assign adv = ~p.out_valid | p.out_ready;
    assign p.in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : st
        localparam int R = W - k * SW;
        logic [R-1:0]        ia, ib;
        logic                ic, nv, v;
        logic [SW-1:0]       ns;
        logic [(k+1)*SW-1:0] nrs, rs;
        if (k == 0) begin : head
            assign ia  = p.a;
            assign ib  = p.sub ? ~p.b : p.b;
            assign ic  = p.sub | p.cin;
            assign nv  = p.in_valid;
            assign nrs = ns;
        end else begin : body
            assign ia  = st[k-1].fwd.ra;
            assign ib  = st[k-1].fwd.rb;
            assign ic  = st[k-1].fwd.rc;
            assign nv  = st[k-1].v;
            assign nrs = {ns, st[k-1].rs};
        end
        // each group precomputes both carry-in cases; the incoming carry only drives muxes
        for (genvar g = 0; g < G; g++) begin : grp
            logic           ci, co;
            logic [BLK:0]   s0, s1;
            if (g == 0) begin : f
                assign ci = ic;
            end else begin : n
                assign ci = grp[g-1].co;
            end
            assign s0 = {1'b0, ia[g*BLK +: BLK]} + {1'b0, ib[g*BLK +: BLK]};
            assign s1 = {1'b0, ia[g*BLK +: BLK]} + {1'b0, ib[g*BLK +: BLK]} + (BLK+1)'(1);
            assign ns[g*BLK +: BLK] = ci ? s1[BLK-1:0] : s0[BLK-1:0];
            assign co = ci ? s1[BLK] : s0[BLK];
        end
        always_ff @(posedge clk)
            if (rst) begin
                v  <= 1'b0;
                rs <= '0;
            end else if (adv) begin
                v  <= nv;
                rs <= nrs;
            end
        if (k < STAGES - 1) begin : fwd
            logic [R-SW-1:0] ra, rb;
            logic            rc;
            always_ff @(posedge clk)
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                    rc <= 1'b0;
                end else if (adv) begin
                    ra <= ia[R-1:SW];
                    rb <= ib[R-1:SW];
                    rc <= grp[G-1].co;
                end
        end else begin : last
            logic co, ov, z;
            always_ff @(posedge clk)
                if (rst) begin
                    co <= 1'b0;
                    ov <= 1'b0;
                    z  <= 1'b0;
                end else if (adv) begin
                    co <= grp[G-1].co;
                    ov <= (ia[R-1] == ib[R-1]) & (ns[SW-1] != ia[R-1]);
                    z  <= ~|nrs;
                end
        end
    end
    assign p.out_valid = st[STAGES-1].v;
    assign p.sum       = st[STAGES-1].rs;
    assign p.cout      = st[STAGES-1].last.co;
    assign p.overflow  = st[STAGES-1].last.ov;
    assign p.zero      = st[STAGES-1].last.z;
endmodule
